// File: rtl/hazard_pkg.sv
// Shared types and default widths for the ID/EX hazard control stage.
// Default bundle widths match the decoder's WB/M/EX control encoding.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUBBLE,
        HOLD
    } state_t;

    localparam int unsigned WB_W_DEF      = 2;
    localparam int unsigned M_W_DEF       = 2;
    localparam int unsigned EX_W_DEF      = 14;
    localparam int unsigned MREAD_BIT_DEF = 1;
    localparam int unsigned REG_AW_DEF    = 5;
    localparam int unsigned CNT_W         = 2;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load sitting in EX and the instruction in ID.
module hazard_detect #(
    parameter int unsigned REG_AW = 5
) (
    input  logic              i_ex_valid,
    input  logic              i_ex_mread,
    input  logic [REG_AW-1:0] i_ex_rt,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_rs,
    input  logic [REG_AW-1:0] i_id_rt,
    output logic              o_hazard
);

    logic w_rs_match;
    logic w_rt_match;

    assign w_rs_match = (i_ex_rt == i_id_rs);
    assign w_rt_match = (i_ex_rt == i_id_rt);

    // Register zero is hardwired, so a load to it never creates a dependency.
    assign o_hazard = i_ex_valid & i_ex_mread & i_id_valid &
                      (i_ex_rt != '0) & (w_rs_match | w_rt_match);

endmodule

// File: rtl/hazard_ctrl_stage.sv
// ID/EX control pipeline register with load-use bubbles, multi-cycle EX hold and flush.
// Optional performance counters (bubble_cnt, hold_cnt) when HAZ_PERF_CNT_EN is defined.
module hazard_ctrl_stage
    import hazard_pkg::*;
#(
    parameter int unsigned WB_W         = WB_W_DEF,
    parameter int unsigned M_W          = M_W_DEF,
    parameter int unsigned EX_W         = EX_W_DEF,
    parameter int unsigned MREAD_BIT    = MREAD_BIT_DEF,
    parameter int unsigned REG_AW       = REG_AW_DEF,
    parameter int unsigned LOAD_BUBBLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WB_W-1:0]   id_wb,
    input  logic [M_W-1:0]    id_m,
    input  logic [EX_W-1:0]   id_ex,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              flush,
    input  logic              ex_busy,
`ifdef HAZ_PERF_CNT_EN
    output logic [31:0]       bubble_cnt,
    output logic [31:0]       hold_cnt,
`endif
    output logic [WB_W-1:0]   ex_wb,
    output logic [M_W-1:0]    ex_m,
    output logic [EX_W-1:0]   ex_ex,
    output logic [REG_AW-1:0] ex_rt,
    output logic              ex_valid,
    output logic              pc_write,
    output logic              ifid_write
);

    logic [WB_W-1:0]   r_ex_wb;
    logic [M_W-1:0]    r_ex_m;
    logic [EX_W-1:0]   r_ex_ex;
    logic [REG_AW-1:0] r_ex_rt;
    logic              r_ex_valid;
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_flush_pending;

    state_t            w_work_state;
    state_t            w_nxt_state;
    logic [CNT_W-1:0]  w_nxt_cnt;
    logic              w_nxt_flush_pending;
    logic              w_load_id;
    logic              w_load_bubble;
    logic              w_haz_bubble;
    logic              w_pc_write;
    logic              w_hazard_raw;
    logic              w_hazard;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .i_ex_valid (r_ex_valid),
        .i_ex_mread (r_ex_m[MREAD_BIT]),
        .i_ex_rt    (r_ex_rt),
        .i_id_valid (id_valid),
        .i_id_rs    (id_rs),
        .i_id_rt    (id_rt),
        .o_hazard   (w_hazard_raw)
    );

    // Leaving HOLD resumes whatever bubble sequence was frozen by the counter.
    always_comb begin
        w_work_state = r_state;
        if (r_state == HOLD) begin
            w_work_state = (r_cnt != '0) ? BUBBLE : IDLE;
        end
    end

    assign w_hazard = w_hazard_raw & (w_work_state == IDLE) & ~ex_busy;

    always_comb begin
        w_nxt_state         = w_work_state;
        w_nxt_cnt           = r_cnt;
        w_nxt_flush_pending = r_flush_pending;
        w_load_id           = 1'b0;
        w_load_bubble       = 1'b0;
        w_haz_bubble        = 1'b0;
        w_pc_write          = 1'b1;
        if (ex_busy) begin
            w_nxt_state = HOLD;
            w_pc_write  = 1'b0;
            if (flush) begin
                w_nxt_flush_pending = 1'b1;
            end
        end else if (flush || r_flush_pending) begin
            w_load_bubble       = 1'b1;
            w_nxt_cnt           = '0;
            w_nxt_state         = IDLE;
            w_nxt_flush_pending = 1'b0;
        end else if (w_work_state == BUBBLE) begin
            w_load_bubble = 1'b1;
            w_haz_bubble  = 1'b1;
            w_pc_write    = 1'b0;
            w_nxt_cnt     = r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
                w_nxt_state = IDLE;
            end
        end else if (w_hazard) begin
            w_load_bubble = 1'b1;
            w_haz_bubble  = 1'b1;
            w_pc_write    = 1'b0;
            if (LOAD_BUBBLES > 1) begin
                w_nxt_cnt   = CNT_W'(LOAD_BUBBLES - 1);
                w_nxt_state = BUBBLE;
            end
        end else begin
            w_load_id = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex_wb         <= '0;
            r_ex_m          <= '0;
            r_ex_ex         <= '0;
            r_ex_rt         <= '0;
            r_ex_valid      <= 1'b0;
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_flush_pending <= 1'b0;
        end else begin
            r_state         <= w_nxt_state;
            r_cnt           <= w_nxt_cnt;
            r_flush_pending <= w_nxt_flush_pending;
            if (w_load_bubble) begin
                r_ex_wb    <= '0;
                r_ex_m     <= '0;
                r_ex_ex    <= '0;
                r_ex_rt    <= '0;
                r_ex_valid <= 1'b0;
            end else if (w_load_id) begin
                r_ex_wb    <= id_wb;
                r_ex_m     <= id_m;
                r_ex_ex    <= id_ex;
                r_ex_rt    <= id_rt;
                r_ex_valid <= id_valid;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_hold_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
            r_hold_cnt   <= '0;
        end else begin
            if (w_haz_bubble && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
            if (ex_busy && (r_hold_cnt != '1)) begin
                r_hold_cnt <= r_hold_cnt + 32'd1;
            end
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign hold_cnt   = r_hold_cnt;
`endif

    assign ex_wb      = r_ex_wb;
    assign ex_m       = r_ex_m;
    assign ex_ex      = r_ex_ex;
    assign ex_rt      = r_ex_rt;
    assign ex_valid   = r_ex_valid;
    assign pc_write   = w_pc_write;
    assign ifid_write = w_pc_write;

endmodule

// File: tb/tb_hazard_ctrl_stage.sv
// Scoreboard bench: three stages (LOAD_BUBBLES = 1, 2, 3) share one stimulus stream.
// Perf counters are also checked when HAZ_PERF_CNT_EN is defined.
module tb_hazard_ctrl_stage;

    typedef struct packed {
        logic [1:0]  wb;
        logic [1:0]  m;
        logic [13:0] ex;
        logic [4:0]  rt;
        logic        v;
        logic        pcw;
        logic        iw;
`ifdef HAZ_PERF_CNT_EN
        logic [31:0] bc;
        logic [31:0] hc;
`endif
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  id_wb;
    logic [1:0]  id_m;
    logic [13:0] id_ex;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        flush;
    logic        ex_busy;

    logic [1:0]  o_wb [3];
    logic [1:0]  o_m  [3];
    logic [13:0] o_ex [3];
    logic [4:0]  o_rt [3];
    logic        o_v  [3];
    logic        o_pcw[3];
    logic        o_iw [3];
    obs_t        got  [3];

    int n_vec = 0;
    int n_err = 0;

    // Reference state: contents of EX, remaining extra bubbles, deferred flush.
    obs_t m_st   [3];
    int   m_stall[3];
    bit   m_pend [3];
    obs_t q_exp  [3][$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
`ifdef HAZ_PERF_CNT_EN
        logic [31:0] bc;
        logic [31:0] hc;
`endif
        hazard_ctrl_stage #(
            .LOAD_BUBBLES (g + 1)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .id_wb      (id_wb),
            .id_m       (id_m),
            .id_ex      (id_ex),
            .id_valid   (id_valid),
            .id_rs      (id_rs),
            .id_rt      (id_rt),
            .flush      (flush),
            .ex_busy    (ex_busy),
`ifdef HAZ_PERF_CNT_EN
            .bubble_cnt (bc),
            .hold_cnt   (hc),
`endif
            .ex_wb      (o_wb[g]),
            .ex_m       (o_m[g]),
            .ex_ex      (o_ex[g]),
            .ex_rt      (o_rt[g]),
            .ex_valid   (o_v[g]),
            .pc_write   (o_pcw[g]),
            .ifid_write (o_iw[g])
        );
`ifdef HAZ_PERF_CNT_EN
        assign got[g] = {o_wb[g], o_m[g], o_ex[g], o_rt[g], o_v[g], o_pcw[g], o_iw[g], bc, hc};
`else
        assign got[g] = {o_wb[g], o_m[g], o_ex[g], o_rt[g], o_v[g], o_pcw[g], o_iw[g]};
`endif
    end

    function automatic bit model_hazard(input int k);
        return m_st[k].v && m_st[k].m[1] && id_valid && (m_st[k].rt != 5'd0) &&
               ((m_st[k].rt == id_rs) || (m_st[k].rt == id_rt));
    endfunction

    function automatic logic model_pcw(input int k);
        if (ex_busy) return 1'b0;
        if (flush || m_pend[k]) return 1'b1;
        if (m_stall[k] > 0) return 1'b0;
        if (model_hazard(k)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge(input int k);
        bit haz;
        haz = model_hazard(k);
        if (!rst_n) begin
            m_st[k]    = '0;
            m_stall[k] = 0;
            m_pend[k]  = 1'b0;
        end else if (ex_busy) begin
            if (flush) m_pend[k] = 1'b1;
`ifdef HAZ_PERF_CNT_EN
            if (m_st[k].hc != 32'hFFFF_FFFF) m_st[k].hc = m_st[k].hc + 1;
`endif
        end else if (flush || m_pend[k]) begin
            m_st[k].wb = '0; m_st[k].m = '0; m_st[k].ex = '0; m_st[k].rt = '0; m_st[k].v = 1'b0;
            m_stall[k] = 0;
            m_pend[k]  = 1'b0;
        end else if (m_stall[k] > 0 || haz) begin
            m_st[k].wb = '0; m_st[k].m = '0; m_st[k].ex = '0; m_st[k].rt = '0; m_st[k].v = 1'b0;
            m_stall[k] = (m_stall[k] > 0) ? m_stall[k] - 1 : k;
`ifdef HAZ_PERF_CNT_EN
            if (m_st[k].bc != 32'hFFFF_FFFF) m_st[k].bc = m_st[k].bc + 1;
`endif
        end else begin
            m_st[k].wb = id_wb; m_st[k].m = id_m; m_st[k].ex = id_ex;
            m_st[k].rt = id_rt; m_st[k].v = id_valid;
        end
    endtask

    // One cycle: the edge consumes the previous inputs, then new inputs are driven.
    task automatic apply(input logic rn, input logic fl, input logic busy, input logic v,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] m, input logic [13:0] ex);
        obs_t e;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_edge(k);
        #2;
        rst_n    = rn;
        flush    = fl;
        ex_busy  = busy;
        id_valid = v;
        id_rs    = rs;
        id_rt    = rt;
        id_m     = m;
        id_ex    = ex;
        id_wb    = 2'($urandom_range(0, 3));
        for (int k = 0; k < 3; k++) begin
            e     = m_st[k];
            e.pcw = model_pcw(k);
            e.iw  = e.pcw;
            q_exp[k].push_back(e);
        end
    endtask

    task automatic check(input int k, input obs_t exp_o, input obs_t got_o);
        n_vec++;
        if (got_o !== exp_o) begin
            n_err++;
            $display("FAIL lb%0d @%0t: got wb=%h m=%h ex=%h rt=%0d v=%b pcw=%b iw=%b, expected wb=%h m=%h ex=%h rt=%0d v=%b pcw=%b iw=%b",
                     k + 1, $time, got_o.wb, got_o.m, got_o.ex, got_o.rt, got_o.v, got_o.pcw, got_o.iw,
                     exp_o.wb, exp_o.m, exp_o.ex, exp_o.rt, exp_o.v, exp_o.pcw, exp_o.iw);
`ifdef HAZ_PERF_CNT_EN
            $display("FAIL lb%0d perf: got bc=%0d hc=%0d, expected bc=%0d hc=%0d",
                     k + 1, got_o.bc, got_o.hc, exp_o.bc, exp_o.hc);
`endif
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (q_exp[k].size() > 0) check(k, q_exp[k].pop_front(), got[k]);
        end
    end

    initial begin
        logic [13:0] rx;
        rst_n = 1'b0; flush = 1'b0; ex_busy = 1'b0; id_valid = 1'b1;
        id_rs = 5'd0; id_rt = 5'd0; id_m = 2'b11; id_ex = 14'h3FFF; id_wb = 2'b11;
        for (int k = 0; k < 3; k++) begin
            m_st[k] = '0; m_stall[k] = 0; m_pend[k] = 1'b0;
        end

        apply(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 2'b11, 14'h3FFF);
        apply(1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 2'b00, 14'h0123);

        // lw rt=5 followed by a consumer of r5; consumer stays in ID while stalled
        apply(1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 5'd5, 2'b10, 14'h0AAA);
        for (int i = 0; i < 5; i++) apply(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd9, 2'b00, 14'h1555);

        // lw to r0, and a load with no matching consumer
        apply(1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 5'd0, 2'b10, 14'h0101);
        apply(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd4, 2'b00, 14'h0202);
        apply(1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 5'd7, 2'b10, 14'h0303);
        apply(1'b1, 1'b0, 1'b0, 1'b1, 5'd6, 5'd8, 2'b00, 14'h0404);

        // four busy cycles with flush in the second, then recovery
        for (int i = 0; i < 4; i++) apply(1'b1, (i == 1), 1'b1, 1'b1, 5'd2, 5'd3, 2'b01, 14'h0505);
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 5'd3, 2'b01, 14'h0606);

        // flush landing on the second bubble of a load-use stall
        apply(1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 5'd5, 2'b10, 14'h0707);
        apply(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd1, 2'b00, 14'h0808);
        apply(1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 5'd1, 2'b00, 14'h0808);
        for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 5'd10, 2'b00, 14'h0909);

        for (int i = 0; i < 3000; i++) begin
            rx = 14'($urandom);
            apply(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) != 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), rx);
        end

        apply(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 14'h0000);
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (q_exp[k].size() != 0) begin
                n_err++;
                $display("FAIL drain lb%0d: %0d entries left, expected 0", k + 1, q_exp[k].size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_stage.md
Name: hazard_ctrl_stage

Overview:
- Parametrised ID/EX control pipeline register with built-in hazard handling.
- Registers the WB/M/EX control bundles and detects load-use hazards.
- Inserts a configurable number of bubbles, holds the stage during multi-cycle EX operations (HiLo mul/div), and squashes on flush.
- Sits between the decoder/control unit and the EX stage; drives PC and IF/ID write enables.

Parameters:
- WB_W, 2, width of write-back control bundle {MemToReg, RegWrite}
- M_W, 2, width of memory control bundle {MemRead, MemWrite}
- EX_W, 14, width of EX control bundle {RegDst, AluOp[8:0], AluSrc, AluMux[1:0], HiLoEnable}
- MREAD_BIT, 1, index of MemRead within the M bundle
- REG_AW, 5, register-specifier width
- LOAD_BUBBLES, 1, bubbles inserted per load-use hazard; legal range 1..3

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- id_wb  in  WB_W  decoded WB controls
- id_m  in  M_W  decoded M controls
- id_ex  in  EX_W  decoded EX controls
- id_valid  in  1  ID holds a real instruction
- id_rs  in  REG_AW  source register rs of ID instruction
- id_rt  in  REG_AW  source/dest register rt of ID instruction
- flush  in  1  squash ID instruction (taken branch/jump)
- ex_busy  in  1  EX multi-cycle unit cannot accept a new instruction
- ex_wb  out  WB_W  registered WB controls
- ex_m  out  M_W  registered M controls
- ex_ex  out  EX_W  registered EX controls
- ex_rt  out  REG_AW  registered rt (load destination)
- ex_valid  out  1  EX holds a real instruction
- pc_write  out  1  PC update enable (combinational)
- ifid_write  out  1  IF/ID register write enable (combinational)

Behaviour:
- Reset (rst_n=0 at posedge): ex_wb, ex_m, ex_ex, ex_rt = 0; ex_valid = 0; state = IDLE; bubble counter = 0; flush_pending = 0.
- Reset dominates every other input, including mid-bubble and mid-hold.
- Hazard (combinational), asserted only in IDLE: ex_valid & ex_m[MREAD_BIT] & id_valid & ex_rt≠0 & (ex_rt==id_rs | ex_rt==id_rt).
- States:
  - IDLE: normal flow.
  - BUBBLE: counter > 0.
  - HOLD: ex_busy.
- Priority per cycle: reset > ex_busy > flush > BUBBLE/hazard > normal.
- ex_busy=1:
  - Stage registers hold their value.
  - pc_write = ifid_write = 0.
  - Counter frozen.
  - If flush is also asserted, set flush_pending.
- Flush (flush=1 or flush_pending, with ex_busy=0):
  - Stage loads all zeros; ex_valid = 0.
  - Counter cleared; state → IDLE; flush_pending cleared.
  - pc_write = ifid_write = 1.
- Hazard in IDLE:
  - Stage loads zeros (bubble); pc_write = ifid_write = 0 this cycle.
  - If LOAD_BUBBLES > 1: counter ← LOAD_BUBBLES−1, state → BUBBLE.
- BUBBLE:
  - Each cycle loads a bubble, holds PC and IF/ID, decrements the counter.
  - At counter=1, the next state is IDLE and the cycle after that loads normally.
- Normal: stage loads id_* with ex_valid = id_valid; pc_write = ifid_write = 1.
- Latency: one cycle from id_* to ex_*; a bubble never copies id_* fields.
- ex_rt is zeroed by every bubble, so a bubble cannot re-trigger a hazard.
- The hazard check is suppressed while in BUBBLE/HOLD.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- Defined: adds 32-bit outputs bubble_cnt (incremented on every hazard/BUBBLE bubble load) and hold_cnt (incremented on every ex_busy cycle).
  - Both reset to 0 and saturate at 0xFFFFFFFF.
  - Flush bubbles are not counted.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package hazard_pkg:
  - state enum {IDLE, BUBBLE, HOLD}.
  - Default bundle widths, MREAD_BIT, counter width (2 bits).
- Sub-module hazard_detect: purely combinational compare of ex_m/ex_rt/ex_valid vs id_rs/id_rt/id_valid, producing hazard.

Test Plan:
- Reset: drive rst_n=0 with id_valid=1, id_ex=14'h3FFF → ex_ex=0, ex_valid=0, pc_write=1 after release.
- Load-use, LOAD_BUBBLES=1:
  - lw rt=5 registered in EX, then ID rs=5 → one bubble (ex_m=0, ex_valid=0).
  - pc_write=0 for exactly 1 cycle; the dependent instruction appears in EX the following cycle.
- LOAD_BUBBLES=2, same sequence → 2 consecutive bubbles and 2 cycles with pc_write=0.
- rt=0 and non-matching registers: lw rt=0 then ID rs=0 → no bubble; lw rt=7 then rs=6, rt=8 → no bubble.
- ex_busy for 4 cycles, with flush pulsed in cycle 2:
  - Stage holds 4 cycles; pc_write=0 throughout.
  - Next cycle loads a bubble (flush_pending honoured).
  - hold_cnt=4 under HAZ_PERF_CNT_EN.
- Flush mid-BUBBLE (LOAD_BUBBLES=3, flush at second bubble) → counter cleared, IDLE, pc_write=1 that cycle, next ID instruction loads normally.
